// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux_pkg
// Brief  : Shared constants, lock-state encoding and channel-id width helper
//          for the stream multiplexer family.
// Rev    : 1.0  initial release
// ============================================================================
package mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Channel-id width; a single channel still gets a 1-bit id.
    function automatic int chw_of(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin / fixed-priority arbiter with a one-hot grant and an
//          externally strobed pointer update.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int M        = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int CHW      = chw_of(M)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M-1:0]   req,
    input  logic           ptr_upd,
    input  logic [CHW-1:0] ptr_nxt,
    output logic [M-1:0]   grant
);

    logic [CHW-1:0] r_ptr;
    logic [CHW-1:0] w_start;
    logic [CHW-1:0] w_idx;
    logic           w_found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (ptr_upd) begin
            r_ptr <= ptr_nxt;
        end
    end

    // With no request the start channel is still granted, keeping the grant
    // one-hot; nothing transfers because its valid is low.
    always_comb begin
        w_start = (ARB_MODE == ARB_FIXED) ? '0 : r_ptr;
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < M; i++) begin
            w_idx = CHW'((int'(w_start) + i) % M);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
        if (!w_found) begin
            grant[w_start] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_stream_arb.sv
`default_nettype none
// ============================================================================
// Module : mux_stream_arb
// Brief  : M-channel valid/ready stream multiplexer with arbitration, packet
//          locking and a single registered output stage.
// Rev    : 1.0  initial release
// ============================================================================
module mux_stream_arb
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int M        = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int CHW      = chw_of(M)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [M-1:0]       in_valid,
    input  logic [M*WIDTH-1:0] in_data,
    input  logic [M-1:0]       in_last,
    output logic [M-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [CHW-1:0]     out_chan,
    input  logic               out_ready
);

    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [CHW-1:0]   r_lock_chan;
    logic [CHW-1:0]   w_lock_chan_nxt;

    logic [M-1:0]     w_arb_grant;
    logic [M-1:0]     w_sel_oh;
    logic [CHW-1:0]   w_sel_idx;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;
    logic             w_load_en;
    logic             w_xfer;
    logic             w_ptr_upd;
    logic [CHW-1:0]   w_ptr_nxt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [CHW-1:0]   r_out_chan;

    assign w_load_en = !r_out_valid || out_ready;

    rr_arbiter #(
        .M        (M),
        .ARB_MODE (ARB_MODE),
        .CHW      (CHW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .ptr_upd (w_ptr_upd),
        .ptr_nxt (w_ptr_nxt),
        .grant   (w_arb_grant)
    );

    // A locked packet overrides the arbiter, independent of its own valid.
    always_comb begin
        w_sel_oh   = (r_state == ST_LOCKED) ? '0 : w_arb_grant;
        w_sel_idx  = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int c = 0; c < M; c++) begin
            if ((r_state == ST_LOCKED) && (r_lock_chan == CHW'(c))) begin
                w_sel_oh[c] = 1'b1;
            end
        end
        for (int c = 0; c < M; c++) begin
            if (w_sel_oh[c]) begin
                w_sel_idx  = CHW'(c);
                w_sel_data = in_data[c*WIDTH +: WIDTH];
                w_sel_last = in_last[c];
            end
        end
    end

    assign in_ready  = (rst_n && w_load_en) ? w_sel_oh : '0;
    assign w_xfer    = |(in_valid & in_ready);
    assign w_ptr_upd = w_xfer && w_sel_last;
    assign w_ptr_nxt = (w_sel_idx == CHW'(M - 1)) ? '0 : w_sel_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lock_chan <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_chan <= w_lock_chan_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lock_chan_nxt = r_lock_chan;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !w_sel_last) begin
                    w_state_nxt     = ST_LOCKED;
                    w_lock_chan_nxt = w_sel_idx;
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_chan  <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_last <= w_sel_last;
                r_out_chan <= w_sel_idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mux_stream_arb
// Brief  : Self-checking bench: RR and fixed-priority instances share stimulus
//          and are compared against a behavioural per-beat model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux_stream_arb;

    localparam int M     = 4;
    localparam int WIDTH = 8;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [31:0]  in_data;
    logic         out_ready;

    logic [3:0]   rdy_rr, rdy_fp;
    logic         ov_rr, ov_fp;
    logic [7:0]   od_rr, od_fp;
    logic         ol_rr, ol_fp;
    logic [1:0]   oc_rr, oc_fp;

    mux_stream_arb #(.WIDTH(WIDTH), .M(M), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_rr), .out_valid(ov_rr),
        .out_data(od_rr), .out_last(ol_rr), .out_chan(oc_rr),
        .out_ready(out_ready)
    );

    mux_stream_arb #(.WIDTH(WIDTH), .M(M), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_fp), .out_valid(ov_fp),
        .out_data(od_fp), .out_last(ol_fp), .out_chan(oc_fp),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model, index 0 = round-robin, 1 = fixed priority.
    bit         m_ov [2];
    logic [7:0] m_od [2];
    bit         m_ol [2];
    int         m_oc [2];
    bit         m_lk [2];
    int         m_lch[2];
    int         m_ptr[2];

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [3:0] l;
        logic       ordy;
        bit         chk_rdy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_chan;
    } vec_t;

    vec_t tbl[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input int mi, input logic [3:0] v);
        int start;
        if (m_lk[mi]) return m_lch[mi];
        start = (mi == 1) ? 0 : m_ptr[mi];
        for (int k = 0; k < M; k++) begin
            if (v[(start + k) % M]) return (start + k) % M;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'h40 + b, 8'h30 + b, 8'h20 + b, 8'h10 + b};
    endfunction

    // Drives one cycle of inputs, checks both DUTs before the edge, advances the model.
    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] d, input logic ordy, input bit en);
        logic [3:0] a_rdy;
        logic       a_ov, a_ol;
        logic [7:0] a_od;
        logic [1:0] a_oc;
        bit         le, xfer;
        int         g;
        string      pfx;
        @(negedge clk);
        rst_n     = r;
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        #1;
        for (int mi = 0; mi < 2; mi++) begin
            pfx   = (mi == 0) ? "rr" : "fp";
            a_rdy = (mi == 0) ? rdy_rr : rdy_fp;
            a_ov  = (mi == 0) ? ov_rr  : ov_fp;
            a_od  = (mi == 0) ? od_rr  : od_fp;
            a_ol  = (mi == 0) ? ol_rr  : ol_fp;
            a_oc  = (mi == 0) ? oc_rr  : oc_fp;
            le    = !m_ov[mi] || ordy;
            g     = pick(mi, v);
            if (en) begin
                if (!r)
                    check($sformatf("%s_rst_ready", pfx), 32'(a_rdy), 32'd0);
                else if (g >= 0)
                    check($sformatf("%s_ready", pfx), 32'(a_rdy), le ? (32'd1 << g) : 32'd0);
                else
                    check($sformatf("%s_ready_idle", pfx),
                          32'(($countones(a_rdy) <= 1) && (le || a_rdy == 4'd0)), 32'd1);
                check($sformatf("%s_out_valid", pfx), 32'(a_ov), 32'(m_ov[mi]));
                if (m_ov[mi]) begin
                    check($sformatf("%s_out_data", pfx), 32'(a_od), 32'(m_od[mi]));
                    check($sformatf("%s_out_last", pfx), 32'(a_ol), 32'(m_ol[mi]));
                    check($sformatf("%s_out_chan", pfx), 32'(a_oc), 32'(m_oc[mi]));
                end
            end
            if (!r) begin
                m_ov[mi] = 0; m_od[mi] = 8'd0; m_ol[mi] = 0; m_oc[mi] = 0;
                m_lk[mi] = 0; m_lch[mi] = 0; m_ptr[mi] = 0;
            end else begin
                xfer = le && (g >= 0) && v[g];
                if (le) m_ov[mi] = xfer;
                if (xfer) begin
                    m_od[mi] = d[g*8 +: 8];
                    m_ol[mi] = l[g];
                    m_oc[mi] = g;
                    if (!m_lk[mi] && !l[g]) begin
                        m_lk[mi]  = 1;
                        m_lch[mi] = g;
                    end else if (m_lk[mi] && l[g]) begin
                        m_lk[mi] = 0;
                    end
                    if (l[g]) m_ptr[mi] = (g + 1) % M;
                end
            end
        end
    endtask

    initial begin
        logic [3:0] v;
        int         exp_g, prev_g;

        rst_n = 1'b0; in_valid = 4'd0; in_last = 4'd0; in_data = 32'd0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = 0; m_od[i] = 8'd0; m_ol[i] = 0; m_oc[i] = 0;
            m_lk[i] = 0; m_lch[i] = 0; m_ptr[i] = 0;
        end

        //          r     v        l        ordy  chk   e_rdy    e_ov  e_chan
        tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[4]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[5]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[6]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[8]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[9]  = '{1'b1, 4'b0111, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[10] = '{1'b1, 4'b0111, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{1'b1, 4'b0111, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[12] = '{1'b1, 4'b1011, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[13] = '{1'b1, 4'b0011, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[14] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[15] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[16] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[17] = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[18] = '{1'b1, 4'b1101, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[19] = '{1'b1, 4'b1101, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[20] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[21] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[22] = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd2};
        tbl[23] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd1};
        tbl[24] = '{1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[25] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};

        step(1'b0, 4'b1111, 4'b1111, 32'd0, 1'b1, 1'b0);

        // Reset, RR fairness, packet lock, lock with idle owner, reset mid-packet.
        for (int i = 0; i < 26; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].l, pat(i), tbl[i].ordy, 1'b1);
            if (tbl[i].chk_rdy)
                check($sformatf("tbl%0d_ready", i), 32'(rdy_rr), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_valid", i), 32'(ov_rr), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov || !tbl[i].r)
                check($sformatf("tbl%0d_chan", i), 32'(oc_rr), 32'(tbl[i].e_chan));
        end

        // Fixed priority: ch3 always valid, ch1 valid for cycles 4..7.
        step(1'b0, 4'b0000, 4'b0000, 32'd0, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 32'd0, 1'b1, 1'b1);
        prev_g = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            v     = {1'b1, 1'b0, (cyc >= 4 && cyc < 8), 1'b0};
            exp_g = v[1] ? 1 : 3;
            step(1'b1, v, 4'b1111, pat(cyc + 40), 1'b1, 1'b1);
            check($sformatf("fp%0d_ready", cyc), 32'(rdy_fp), 32'd1 << exp_g);
            if (prev_g >= 0) begin
                check($sformatf("fp%0d_valid", cyc), 32'(ov_fp), 32'd1);
                check($sformatf("fp%0d_chan", cyc), 32'(oc_fp), 32'(prev_g));
            end
            prev_g = exp_g;
        end

        // Backpressure: hold 0xA5 for 5 stalled cycles, then release.
        step(1'b1, 4'b0001, 4'b1111, 32'h0000_00A5, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'b1111, 4'b1111, $urandom, 1'b0, 1'b1);
            check($sformatf("bp%0d_data_rr", k), 32'(od_rr), 32'hA5);
            check($sformatf("bp%0d_data_fp", k), 32'(od_fp), 32'hA5);
            check($sformatf("bp%0d_ready", k), 32'({rdy_rr, rdy_fp}), 32'd0);
            check($sformatf("bp%0d_valid", k), 32'({ov_rr, ov_fp}), 32'h3);
        end
        step(1'b1, 4'b0010, 4'b1111, 32'h0000_3C00, 1'b1, 1'b1);
        check("bp_release_data", 32'(od_rr), 32'hA5);
        check("bp_release_ready", 32'(rdy_rr), 32'b0010);
        step(1'b1, 4'b0000, 4'b0000, 32'd0, 1'b1, 1'b1);
        check("bp_next_data", 32'(od_rr), 32'h3C);
        check("bp_next_chan", 32'(oc_rr), 32'd1);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) != 0), 4'($urandom), 4'($urandom & $urandom),
                 $urandom, ($urandom_range(0, 3) != 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
